icache_fetch: RTL and testbench

- Direct-mapped instruction cache forming the fetch stage. It sits between the PC register and the I→D pipeline register, and replaces the flat instruction memory.
- It takes the current PC and returns the instruction word plus the fetch stall that freezes the PC register and erases the I→D register.
- On a miss it fills a whole line from a word-wide backing memory port using a request/ack handshake followed by per-word valid beats.

---
 rtl/icache_fetch.sv | 125 ++++++++++++
 tb/tb_icache_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped fetch-stage I-cache; hits are combinational, a miss costs IDLE + REQ + LINE_WORDS beats.
// Fills ignore the downstream stall; optional hit/miss counters are enabled by ICACHE_STATS_EN.
module icache_fetch #(
  parameter int ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 32'h1000,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] pc,
  input  logic                    I_stall_in,
  output logic [ADDRESS_SIZE-1:0] I_instruction,
  output logic                    I_stall,
  output logic                    mem_req,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  input  logic                    mem_ack,
  input  logic                    mem_rvalid,
  input  logic [ADDRESS_SIZE-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int LSB_IDX = OFF_W + 2;
  localparam int LSB_TAG = IDX_W + OFF_W + 2;
  localparam int TAG_W   = ADDRESS_SIZE - LSB_TAG;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                  state;
  logic [NUM_LINES-1:0]    valid;
  logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
  logic [ADDRESS_SIZE-1:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [OFF_W-1:0]        word_cnt;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             miss;
  logic             last_beat;
  logic             unused_bits;

  assign pc_off = pc[LSB_IDX-1:2];
  assign pc_idx = pc[LSB_TAG-1:LSB_IDX];
  assign pc_tag = pc[ADDRESS_SIZE-1:LSB_TAG];

  // mem_addr doubles as the latched fill address for the whole REQ/FILL sequence.
  assign fill_idx = mem_addr[LSB_TAG-1:LSB_IDX];
  assign fill_tag = mem_addr[ADDRESS_SIZE-1:LSB_TAG];

  assign hit           = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign miss          = !hit || (state != IDLE);
  assign I_stall       = miss || I_stall_in;
  assign I_instruction = miss ? '0 : data_mem[{pc_idx, pc_off}];
  assign last_beat     = (state == FILL) && mem_rvalid && (word_cnt == OFF_W'(LINE_WORDS - 1));
  assign unused_bits   = ^{pc[1:0], BOOT_ADDRESS};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            mem_addr       <= {pc[ADDRESS_SIZE-1:LSB_IDX], {LSB_IDX{1'b0}}};
            valid[pc_idx]  <= 1'b0;
            mem_req        <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_beat) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays carry no reset; valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (!reset && (state == FILL) && mem_rvalid) begin
      data_mem[{fill_idx, word_cnt}] <= mem_rdata;
      if (last_beat) tag_mem[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((state == IDLE) && hit && !I_stall_in && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if ((state == IDLE) && !hit && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: a line-level cache model predicts fills and fetched words.
module tb_icache_fetch;
  localparam int LW     = 4;
  localparam int NL     = 8;
  localparam int LINE_B = LW * 4;

  logic        clk, reset, I_stall_in, I_stall, mem_req, mem_ack, mem_rvalid;
  logic [31:0] pc, I_instruction, mem_addr, mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_fetch #(.ADDRESS_SIZE(32), .BOOT_ADDRESS(32'h1000), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .pc(pc), .I_stall_in(I_stall_in),
    .I_instruction(I_instruction), .I_stall(I_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  bit          mv[NL];
  logic [31:0] mt[NL];
  int          n_fills = 0;
  bit          rnd = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mv[i] = 0;
    n_fills = 0;
  endtask

  // One fetch: predict hit/miss from the model, queue expectations, wait for delivery.
  task automatic access(input logic [31:0] a, input bit exact);
    logic [31:0] line;
    int idx, st;
    bit h, done;
    line = a & ~(LINE_B - 1);
    idx  = (a / LINE_B) % NL;
    h    = mv[idx] && (mt[idx] == line);
    if (!h) begin
      addr_q.push_back(line);
      mv[idx] = 1;
      mt[idx] = line;
      n_fills++;
    end
    exp_q.push_back(memfn(a));
    pc = a;
    st = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!I_stall) done = 1;
      else st++;
    end
    chk("fetch_timeout", {31'd0, done}, 32'd1);
    if (h) begin
      chk("hit_stall_cycles", st, 0);
      chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
    end else if (exact) chk("miss_stall_cycles", st, 2 + LW);
    else chk("miss_stall_min", {31'd0, st >= 2 + LW}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: every delivered word pops one expectation.
  always @(negedge clk) begin
    if (!reset && !I_stall) begin
      if (exp_q.size() == 0) chk("unexpected_fetch", I_instruction, 32'hXXXX_XXXX);
      else chk("fetch_word", I_instruction, exp_q.pop_front());
    end else if (I_stall && !I_stall_in) begin
      chk("zero_on_miss", I_instruction, 32'd0);
    end
  end

  // Backing memory: ack after a delay, return the line in ascending order.
  initial begin
    logic [31:0] a;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !reset) begin
        mem_rvalid = 0;
        a = mem_addr;
        if (addr_q.size() == 0) chk("unexpected_fill", a, 32'hXXXX_XXXX);
        else chk("fill_addr", a, addr_q.pop_front());
        if (rnd) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk("req_held", {31'd0, mem_req}, 32'd1);
            chk("addr_held", mem_addr, a);
          end
        end
        mem_ack = 1;
        if (rnd && $urandom_range(0, 1) == 1) begin
          mem_rvalid = 1;
          mem_rdata  = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        mem_ack = 0;
        mem_rvalid = 0;
        for (int i = 0; i < LW; i++) begin
          if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          mem_rvalid = 1;
          mem_rdata  = memfn(a + 32'(4 * i));
          @(posedge clk); #1;
          mem_rvalid = 0;
        end
      end else begin
        mem_rvalid = rnd && ($urandom_range(0, 7) == 0);
        mem_rdata  = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int beats;
    logic [31:0] a, hc0;
    reset = 1; pc = 32'h1000; I_stall_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_stall", {31'd0, I_stall}, 32'd1);
`ifdef ICACHE_STATS_EN
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 0;

    access(32'h1000, 1);
    access(32'h1004, 1);
    access(32'h1008, 1);
    access(32'h100C, 1);
    access(32'h1080, 1);
    access(32'h1000, 1);

    // Redirect while the 0x1010 line is filling.
    pc = 32'h1010;
    addr_q.push_back(32'h1010);
    mv[1] = 1; mt[1] = 32'h1010; n_fills++;
    beats = 0;
    for (int c = 0; c < 100 && beats == 0; c++) begin
      @(negedge clk);
      if (mem_rvalid) beats++;
    end
    chk("redirect_fill_started", beats, 1);
    @(posedge clk); #1;
    access(32'h2000, 0);
    access(32'h1014, 1);

    // Reset after two fill beats.
    pc = 32'h1000;
    addr_q.push_back(32'h1000);
    beats = 0;
    for (int c = 0; c < 100 && beats < 2; c++) begin
      @(negedge clk);
      if (mem_rvalid) beats++;
    end
    chk("midfill_beats", beats, 2);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("midfill_req_drop", {31'd0, mem_req}, 32'd0);
    chk("midfill_stall", {31'd0, I_stall}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    access(32'h1000, 1);

    // Downstream stall on a hit.
    I_stall_in = 1;
    pc = 32'h1004;
    @(negedge clk);
    chk("dstall_stall", {31'd0, I_stall}, 32'd1);
    chk("dstall_word", I_instruction, memfn(32'h1004));
`ifdef ICACHE_STATS_EN
    hc0 = hit_count;
    @(negedge clk);
    chk("dstall_hit_count", hit_count, hc0);
    chk("miss_count_fills", miss_count, n_fills);
`endif
    @(posedge clk); #1;
    I_stall_in = 0;
    access(32'h1004, 1);

    rnd = 1;
    for (int n = 0; n < 150; n++) begin
      a = 32'h1000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, NL - 1) << 4)
          + ($urandom_range(0, LW - 1) << 2);
      access(a, 0);
    end
`ifdef ICACHE_STATS_EN
    chk("miss_count_final", miss_count, n_fills);
`endif

    I_stall_in = 1;
    rnd = 0;
    repeat (4) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
